// File: rtl/ssram_pkg.sv
// Shared types and sizes for the SSRAM register-bank master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ssram_pkg;

  localparam int ADDR_W   = 8;
  localparam int SEL_W    = 16;
  localparam int NIBBLE_W = 4;

  // Transfer sequencer: select phase is SETUP+ACCESS, TURN is the bus turnaround gap
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    TURN   = 2'd3
  } state_e;

endpackage

// File: rtl/ssram_if.sv
// Host request/response and bank select signals of the SSRAM master.
// Latency: n/a (wiring only).
// Backpressure: busy from master tells the host its request is being ignored.
interface ssram_if
  import ssram_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;
  logic              ack;
  logic              busy;
  logic [SEL_W-1:0]  row;
  logic [SEL_W-1:0]  column;
  logic              we;
  logic              re;

  modport master (
    input  req, wr, addr, wdata,
    output rdata, ack, busy, row, column, we, re
  );

  modport slave (
    output req, wr, addr, wdata,
    input  rdata, ack, busy, row, column, we, re
  );

endinterface

// File: rtl/buffer_z.sv
// Tri-state driver onto a shared bus.
// Latency: combinational.
// Backpressure: none; released to high-Z whenever oe_i is low.
module buffer_z #(
  parameter int WIDTH = 16
) (
  input  logic             oe_i,
  input  logic [WIDTH-1:0] d_i,
  inout  wire  [WIDTH-1:0] z_io
);

  assign z_io = oe_i ? d_i : {WIDTH{1'bz}};

endmodule

// File: rtl/ssram_onehot_dec.sv
// 4-to-16 one-hot decoder for row/column bank selects.
// Latency: combinational.
// Backpressure: none.
module ssram_onehot_dec
  import ssram_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nib_i,
  output logic [SEL_W-1:0]    onehot_o
);

  // set exactly the bit addressed by the nibble
  always_comb begin
    onehot_o = SEL_W'(1) << nib_i;
  end

endmodule

// File: rtl/ssram_master.sv
// Sequences one host read/write into a 2-cycle row/column select window on a register bank.
// Latency: ack 3 cycles after the accepting edge; one transfer per 4 cycles at most.
// Backpressure: req is ignored (not queued) while busy is high.
module ssram_master
  import ssram_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  ssram_if.master         bus,
  inout  wire [WIDTH-1:0] data
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [SEL_W-1:0]  row_q, row_d, col_q, col_d;
  logic [SEL_W-1:0]  row_dec, col_dec;
  logic              we_q, we_d, re_q, re_d, oe_q, oe_d;
  logic              ack_q, ack_d, busy_q, busy_d;
  logic              sel_on;

  // Decoders look at the next latched address so selects can be registered
  // and still appear in the very first SETUP cycle.
  ssram_onehot_dec u_row_dec (.nib_i(addr_d[ADDR_W-1:NIBBLE_W]), .onehot_o(row_dec));
  ssram_onehot_dec u_col_dec (.nib_i(addr_d[NIBBLE_W-1:0]),      .onehot_o(col_dec));

  // capture the host command only when it is accepted out of IDLE
  always_comb begin
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && bus.req) begin
      addr_d  = bus.addr;
      wr_d    = bus.wr;
      wdata_d = bus.wdata;
    end
  end

  // next state and next values of every registered output
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    sel_on  = (state_d == SETUP) || (state_d == ACCESS);
    row_d   = sel_on ? row_dec : '0;
    col_d   = sel_on ? col_dec : '0;
    we_d    = sel_on & wr_d;
    re_d    = sel_on & ~wr_d;
    oe_d    = sel_on & wr_d;
    ack_d   = (state_d == TURN);
    busy_d  = (state_d != IDLE);

    // read data is sampled off the bank bus as ACCESS ends; writes leave it alone
    rdata_d = rdata_q;
    if (state_q == ACCESS && !wr_q) rdata_d = data;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // latched command and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      row_q   <= row_d;
      col_q   <= col_d;
      we_q    <= we_d;
      re_q    <= re_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  buffer_z #(.WIDTH(WIDTH)) u_data_drv (
    .oe_i (oe_q),
    .d_i  (wdata_q),
    .z_io (data)
  );

  assign bus.rdata  = rdata_q;
  assign bus.ack    = ack_q;
  assign bus.busy   = busy_q;
  assign bus.row    = row_q;
  assign bus.column = col_q;
  assign bus.we     = we_q;
  assign bus.re     = re_q;

endmodule

// File: tb/tb_ssram_master.sv
// Self-checking bench for ssram_master: random and directed transfers against a cycle-phase reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ssram_master;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wire [W-1:0] data;

  ssram_if #(.WIDTH(W)) bus ();

  ssram_master #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .data (data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model: cycles since acceptance ----------------
  int              ph      = 0;      // 0 idle, 1/2 select window, 3 completion cycle
  logic [7:0]      m_addr  = '0;
  logic            m_wr    = 1'b0;
  logic [W-1:0]    m_wdata = '0;
  logic [W-1:0]    m_rdata = '0;
  logic [W-1:0]    ref_mem  [256] = '{default: '0};

  // ---------------- bank model driven by the DUT's pins ----------------
  logic [W-1:0]    bank_mem [256] = '{default: '0};
  logic [15:0]     prev_row = '0;
  logic [15:0]     prev_col = '0;
  logic [W-1:0]    probe    = '0;
  int              edges    = 0;
  logic            chk_en   = 1'b0;

  function automatic logic [7:0] sel_idx(input logic [15:0] r, input logic [15:0] c);
    logic [7:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (r[i]) idx[7:4] = 4'(i);
      if (c[i]) idx[3:0] = 4'(i);
    end
    return idx;
  endfunction

  logic         m_on;
  logic         exp_drv;
  logic [W-1:0] bank_val;
  assign m_on     = (ph == 1) || (ph == 2);
  assign exp_drv  = m_on && m_wr;
  // bank returns its contents while read-enabled, otherwise it parks a random
  // value on the bus so any stray master drive shows up as a corrupted value
  assign bank_val = bus.re ? bank_mem[sel_idx(bus.row, bus.column)] : probe;
  assign data     = exp_drv ? {W{1'bz}} : bank_val;

  always @(posedge clk) begin
    edges <= edges + 1;
    probe <= W'($urandom);
    // a write reaches storage when its ACCESS cycle ends, reset or not
    if (ph == 2 && m_wr) ref_mem[m_addr] <= m_wdata;
    if (!rst) begin
      ph      <= 0;
      m_addr  <= '0;
      m_wr    <= 1'b0;
      m_wdata <= '0;
      m_rdata <= '0;
    end else if (ph == 0) begin
      if (bus.req) begin
        ph      <= 1;
        m_addr  <= bus.addr;
        m_wr    <= bus.wr;
        m_wdata <= bus.wdata;
      end
    end else begin
      if (ph == 2 && !m_wr) m_rdata <= ref_mem[m_addr];
      ph <= (ph + 1) % 4;
    end
  end

  always @(posedge clk) begin
    if (bus.we && ((bus.row & prev_row) != '0) && ((bus.column & prev_col) != '0))
      bank_mem[sel_idx(bus.row, bus.column)] <= data;
    prev_row <= bus.row;
    prev_col <= bus.column;
  end

  // every-cycle comparison of all outputs and the shared bus against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("row",   32'(bus.row),    32'(m_on ? (16'h1 << m_addr[7:4]) : 16'h0));
      check("col",   32'(bus.column), 32'(m_on ? (16'h1 << m_addr[3:0]) : 16'h0));
      check("we",    32'(bus.we),     32'(m_on && m_wr));
      check("re",    32'(bus.re),     32'(m_on && !m_wr));
      check("ack",   32'(bus.ack),    32'(ph == 3));
      check("busy",  32'(bus.busy),   32'(ph != 0));
      check("rdata", 32'(bus.rdata),  32'(m_rdata));
      check("data",  32'(data),       32'(exp_drv ? m_wdata : bank_val));
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0]  s_row   [5];
  logic [15:0]  s_col   [5];
  logic         s_we    [5];
  logic         s_ack   [5];
  logic [W-1:0] s_rdata [5];

  logic [7:0]   corners [4] = '{8'h00, 8'h0F, 8'hF0, 8'hFF};
  logic [15:0]  c_row   [4] = '{16'h0001, 16'h0001, 16'h8000, 16'h8000};
  logic [15:0]  c_col   [4] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
  int           exp_ack [3] = '{3, 7, 11};
  int           ack_cyc [$];
  int           base;

  // one request accepted at the next edge, then snapshots of cycles 1..4
  task automatic issue(input logic w, input logic [7:0] a, input logic [W-1:0] d);
    bus.req   = 1'b1;
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.req   = 1'b0;
    bus.wr    = 1'($urandom);
    bus.addr  = 8'($urandom);
    bus.wdata = W'($urandom);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      s_row[k]   = bus.row;
      s_col[k]   = bus.column;
      s_we[k]    = bus.we;
      s_ack[k]   = bus.ack;
      s_rdata[k] = bus.rdata;
    end
  endtask

  task automatic chk_reset(input string pfx);
    check({pfx, "_busy"},  32'(bus.busy),   32'd0);
    check({pfx, "_ack"},   32'(bus.ack),    32'd0);
    check({pfx, "_row"},   32'(bus.row),    32'd0);
    check({pfx, "_col"},   32'(bus.column), 32'd0);
    check({pfx, "_we"},    32'(bus.we),     32'd0);
    check({pfx, "_re"},    32'(bus.re),     32'd0);
    check({pfx, "_rdata"}, 32'(bus.rdata),  32'd0);
  endtask

  initial begin
    bus.req   = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    chk_en = 1'b1;
    rst    = 1'b1;
    @(negedge clk);

    // write 3A then read it back
    issue(1'b1, 8'h3A, 16'hBEEF);
    for (int k = 1; k <= 2; k++) begin
      check("w3a_row", 32'(s_row[k]), 32'h0008);
      check("w3a_col", 32'(s_col[k]), 32'h0400);
      check("w3a_we",  32'(s_we[k]),  32'd1);
    end
    check("w3a_ack_c2", 32'(s_ack[2]), 32'd0);
    check("w3a_ack_c3", 32'(s_ack[3]), 32'd1);
    issue(1'b0, 8'h3A, 16'h0000);
    check("r3a_ack_c3",  32'(s_ack[3]),   32'd1);
    check("r3a_rdata",   32'(s_rdata[3]), 32'hBEEF);

    // never-written location reads as zero
    issue(1'b0, 8'h55, 16'hFFFF);
    check("r55_ack_c3", 32'(s_ack[3]),   32'd1);
    check("r55_rdata",  32'(s_rdata[3]), 32'h0000);

    // address corners
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, corners[i], 16'hC000 | 16'(i));
      check("corner_row", 32'(s_row[1]), 32'(c_row[i]));
      check("corner_col", 32'(s_col[1]), 32'(c_col[i]));
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, corners[i], W'($urandom));
      check("corner_rd", 32'(s_rdata[4]), 32'(16'hC000 | 16'(i)));
    end

    // req held high for 12 cycles
    base = edges;
    ack_cyc.delete();
    bus.req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      bus.addr  = {4'h2, 4'($urandom)};
      bus.wr    = 1'($urandom);
      bus.wdata = W'($urandom);
      @(negedge clk);
      if (k == 12) bus.req = 1'b0;
      if (bus.ack) ack_cyc.push_back(edges - base);
    end
    check("hold_nacks", 32'(ack_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("hold_ack_cycle", 32'((i < ack_cyc.size()) ? ack_cyc[i] : -1), 32'(exp_ack[i]));

    // reset during SETUP of a write
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 8'h11; bus.wdata = 16'h1234;
    @(posedge clk); #1; bus.req = 1'b0;
    @(negedge clk);
    check("abS_busy_c1", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("abS");
    rst = 1'b1;
    @(negedge clk);
    check("abS_ack_c3", 32'(bus.ack), 32'd0);
    issue(1'b0, 8'h11, 16'h0000);
    check("abS_not_written", 32'(s_rdata[4] == 16'h1234), 32'd0);
    check("abS_read",        32'(s_rdata[4]), 32'h0000);

    // reset during ACCESS of a write
    bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 8'h11; bus.wdata = 16'h1234;
    @(posedge clk); #1; bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abA_we_c2", 32'(bus.we), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("abA");
    rst = 1'b1;
    @(negedge clk);
    check("abA_ack_c4", 32'(bus.ack), 32'd0);
    issue(1'b0, 8'h11, 16'h0000);

    // random traffic with random idle gaps
    repeat (80) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom), 8'($urandom), W'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
